// File: rtl/lcd_text_engine.sv
// HD44780-style character-LCD controller: power-up init sequence, then refresh of
// dirty rows from a ROWS x COLS text buffer that can be written at any time.
module lcd_text_engine #(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned PWR_DLY   = 750000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 16,
  parameter int unsigned CMD_DLY   = 2500,
  parameter int unsigned CLR_DLY   = 105000,
  parameter int unsigned DATA_DLY  = 2500,
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             CLK_50,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_char,
  input  logic             clear_req,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RS,
  output logic             LCD_EN,
  output logic             init_done,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned MAX_A   = (PWR_DLY > CLR_DLY) ? PWR_DLY : CLR_DLY;
  localparam int unsigned MAX_B   = (CMD_DLY > DATA_DLY) ? CMD_DLY : DATA_DLY;
  localparam int unsigned MAX_C   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_DLY = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_SCAN, S_ROWCMD, S_ROWDATA} state_t;
  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT, P_NEXT} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dly_c;
  logic [ROW_W-1:0] row_q, row_d, scan_q, scan_d, sel;
  logic [COL_W-1:0] col_q, col_d, col_n;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       data_d, start_data;
  logic             rs_d, en_d, busy_d, init_done_d, frame_done_d;
  logic             start, start_rs, byte_done, found, wr_ok;
  logic [ROWS-1:0]  dirty_q, dirty_clr, wr_set;
  logic [7:0]       text_q [ROWS][COLS];

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input int unsigned r);
    case (r)
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  assign wr_ok = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign col_n = col_q + COL_W'(1);
  // Clear Display needs the long wait; other commands and characters use their own
  assign dly_c = LCD_RS ? CNT_W'(DATA_DLY) :
                 (LCD_DATA == 8'h01) ? CNT_W'(CLR_DLY) : CNT_W'(CMD_DLY);

  always_comb begin
    wr_set = '0;
    if (wr_ok) wr_set[wr_row] = 1'b1;
  end

  // Lowest dirty row at or after the scan pointer
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (dirty_q[i] && (i >= int'(scan_q))) begin
        found = 1'b1;
        sel   = ROW_W'(i);
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_PWR;
      phase_q    <= P_SETUP;
      cnt_q      <= '0;
      row_q      <= '0;
      scan_q     <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      LCD_DATA   <= 8'h00;
      LCD_RS     <= 1'b0;
      LCD_EN     <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      scan_q     <= scan_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      LCD_DATA   <= data_d;
      LCD_RS     <= rs_d;
      LCD_EN     <= en_d;
      busy       <= busy_d;
      init_done  <= init_done_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    scan_d       = scan_q;
    col_d        = col_q;
    idx_d        = idx_q;
    data_d       = LCD_DATA;
    rs_d         = LCD_RS;
    en_d         = LCD_EN;
    busy_d       = busy;
    init_done_d  = init_done;
    frame_done_d = 1'b0;
    dirty_clr    = '0;
    byte_done    = 1'b0;
    start        = 1'b0;
    start_data   = 8'h00;
    start_rs     = 1'b0;

    case (state_q)
      S_PWR: begin
        if (cnt_q == CNT_W'(PWR_DLY - 1)) begin
          state_d    = S_INIT;
          idx_d      = 2'd0;
          start      = 1'b1;
          start_data = init_byte(2'd0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SCAN: begin
        if (found) begin
          state_d        = S_ROWCMD;
          row_d          = sel;
          dirty_clr[sel] = 1'b1;
          start          = 1'b1;
          start_data     = row_cmd(32'(sel));
        end else if (scan_q != '0) begin
          frame_done_d = 1'b1;
          scan_d       = '0;
        end
      end
      default: begin
        case (phase_q)
          P_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
              phase_d = P_PULSE;
              cnt_d   = '0;
              en_d    = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
          end
          P_PULSE: begin
            if (cnt_q == CNT_W'(EN_CYC - 1)) begin
              phase_d = P_WAIT;
              cnt_d   = '0;
              en_d    = 1'b0;
            end else cnt_d = cnt_q + CNT_W'(1);
          end
          P_WAIT: begin
            if (cnt_q == dly_c - CNT_W'(1)) begin
              phase_d = P_NEXT;
              cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
          end
          default: byte_done = 1'b1;
        endcase
      end
    endcase

    // Sequencing after a completed byte
    if (byte_done) begin
      case (state_q)
        S_INIT: begin
          if (idx_q == 2'd3) begin
            state_d     = S_SCAN;
            busy_d      = 1'b0;
            init_done_d = 1'b1;
            scan_d      = '0;
          end else begin
            idx_d      = idx_q + 2'd1;
            start      = 1'b1;
            start_data = init_byte(idx_q + 2'd1);
          end
        end
        S_ROWCMD: begin
          state_d    = S_ROWDATA;
          col_d      = '0;
          start      = 1'b1;
          start_rs   = 1'b1;
          start_data = text_q[row_q][0];
        end
        S_ROWDATA: begin
          if (32'(col_q) == COLS - 1) begin
            state_d = S_SCAN;
            busy_d  = 1'b0;
            if (32'(row_q) == ROWS - 1) begin
              frame_done_d = 1'b1;
              scan_d       = '0;
            end else begin
              scan_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d      = col_n;
            start      = 1'b1;
            start_rs   = 1'b1;
            start_data = text_q[row_q][col_n];
          end
        end
        default: ;
      endcase
    end

    if (start) begin
      phase_d = P_SETUP;
      cnt_d   = '0;
      data_d  = start_data;
      rs_d    = start_rs;
      busy_d  = 1'b1;
    end
  end

  // Text buffer and dirty flags; clear beats a simultaneous write
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++) text_q[r][c] <= 8'h20;
      dirty_q <= '1;
    end else if (clear_req) begin
      for (int r = 0; r < int'(ROWS); r++)
        for (int c = 0; c < int'(COLS); c++) text_q[r][c] <= 8'h20;
      dirty_q <= '1;
    end else begin
      dirty_q <= (dirty_q & ~dirty_clr) | wr_set;
      if (wr_ok) text_q[wr_row][wr_col] <= wr_char;
    end
  end

endmodule
